axil_mst_cmd: RTL and testbench
===============================

# axil_mst_cmd

Single-outstanding AXI4-Lite initiator that turns a simple command/response strobe interface into AXI-Lite read and write transactions. It drives the AXIL_M-side channels of the PL register slave `axil_reg32_2` from fabric logic, such as a bring-up sequencer or self-test, with no PS involvement. One transaction is in flight at a time. AW and W are issued concurrently.

## Interface
Parameters:
- ADDRW, 7, AXI-Lite address width.
- DATAW, 32, AXI-Lite data width; must be 32 or 64.
- TIMEOUT, 1024, watchdog limit in clk100 cycles; used only with the configuration macro.

Ports:
- clk100  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when both this and cmd_valid_i are high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDRW  byte address, passed unmodified.
- cmd_wdata_i  in  DATAW  write data.
- cmd_wstrb_i  in  DATAW/8  write strobes.
- rsp_valid_o  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata_o  out  DATAW  read data; 0 for writes.
- rsp_resp_o  out  2  BRESP/RRESP of the completed transaction.
- rsp_timeout_o  out  1  watchdog abort flag, qualified by rsp_valid_o.
- M_AXI_AWADDR/AWPROT/AWVALID (out), M_AXI_AWREADY (in): write address channel; AWPROT = 3'b000.
- M_AXI_WDATA/WSTRB/WVALID (out), M_AXI_WREADY (in): write data channel.
- M_AXI_BRESP (in 2), M_AXI_BVALID (in), M_AXI_BREADY (out): write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID (out), M_AXI_ARREADY (in): read address channel; ARPROT = 3'b000.
- M_AXI_RDATA (in), M_AXI_RRESP (in 2), M_AXI_RVALID (in), M_AXI_RREADY (out): read data channel.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: cmd_ready_o = 1. On acceptance, latch addr/wdata/wstrb/we and go to WR_REQ (we = 1) or RD_REQ (we = 0).
- WR_REQ: AWVALID and WVALID are both high. Two sticky flags, aw_done and w_done, record each handshake. Each VALID drops in the cycle after its own handshake. Handshakes may complete in the same cycle or either order. When both flags are set, go to WR_RESP.
- WR_RESP: BREADY = 1. On the BVALID handshake, capture BRESP and go to DONE.
- RD_REQ: ARVALID = 1. On the ARREADY handshake, go to RD_DATA.
- RD_DATA: RREADY = 1. On the RVALID handshake, capture RDATA and RRESP, then go to DONE.
- DONE: rsp_valid_o = 1 for exactly one cycle, then IDLE. Captured rdata/resp hold until the next DONE.
- VALIDs never depend combinationally on READY inputs. Once asserted, a VALID holds until its handshake, except on watchdog abort.
- cmd_valid_i outside IDLE is ignored; the requester holds it.
- Reset mid-transaction: the next edge forces IDLE and all outputs to reset values. The slave must be reset in the same domain.

## Timing
- Reset values: cmd_ready_o = 0 during rst and 1 in the first IDLE cycle after release. All VALID/READY/rsp outputs are 0. rsp_rdata_o = 0, rsp_resp_o = 2'b00, address/data outputs = 0.
- Write with zero-wait slave: accept at T0, AW+W valid at T1, BREADY at T2, BVALID seen at T2, rsp_valid_o at T3, cmd_ready_o at T4. Minimum 4 cycles command-to-command.
- Read with zero-wait slave: same shape. ARVALID at T1, RREADY at T2, rsp at T3.
- All outputs are registered.

## Configuration
- AXIL_MST_TIMEOUT_EN defined: a counter clears on leaving IDLE and increments every non-IDLE, non-DONE cycle. At TIMEOUT it forces DONE with rsp_resp_o = 2'b10 (SLVERR), rsp_rdata_o = 0 and rsp_timeout_o = 1, and drops all VALID/READY. This is a deliberate protocol break, for bring-up only.
- Undefined: no counter; rsp_timeout_o is tied to 0; the block waits indefinitely.

## Structure
- Package axil_pkg holds the resp_t enum (OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3) and the mst_state_t enum.
- One sub-module, axil_mst_wdog (clear/enable/expire counter, width $clog2(TIMEOUT + 1)), is instantiated only under the macro.

## Test plan
- Write 0x0000_0005 to addr 0x08 with wstrb 0xF against axil_reg32_2 -> rsp_valid_o pulse with resp 0; a later read of 0x08 returns 0x0000_0005 and led_div0_o = 5.
- Responder holds AWREADY low 3 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID persists 4 cycles, and exactly one B handshake occurs.
- Read 0x00 with RVALID delayed 5 cycles, RRESP = 2'b11 -> rsp_resp_o = 3, rdata matches, and rsp_valid_o is high for exactly 1 cycle.
- cmd_valid_i held high continuously with 3 queued commands -> exactly 3 rsp pulses, and cmd_ready_o is never high outside IDLE.
- rst asserted in WR_RESP -> next cycle all outputs are at reset values and a subsequent read completes normally.
- With the macro, TIMEOUT = 16, and a silent responder -> rsp_valid_o at cycle 17 after acceptance, with resp 2 and rsp_timeout_o = 1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite command initiator: response codes and FSM states.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } mst_state_t;

endpackage

// File: rtl/axil_mst_wdog.sv
// Transaction watchdog for axil_mst_cmd; only built when AXIL_MST_TIMEOUT_EN is defined.
`ifdef AXIL_MST_TIMEOUT_EN
module axil_mst_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Fires on the TIMEOUT-th enabled cycle, so the abort lands on the following edge.
    assign expire = en && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/axil_mst_cmd.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response strobe interface.
// Optional watchdog abort enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_mst_cmd
    import axil_pkg::*;
#(
    parameter int ADDRW   = 7,
    parameter int DATAW   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADDRW-1:0]   cmd_addr_i,
    input  logic [DATAW-1:0]   cmd_wdata_i,
    input  logic [DATAW/8-1:0] cmd_wstrb_i,
    output logic               rsp_valid_o,
    output logic [DATAW-1:0]   rsp_rdata_o,
    output logic [1:0]         rsp_resp_o,
    output logic               rsp_timeout_o,
    output logic [ADDRW-1:0]   M_AXI_AWADDR,
    output logic [2:0]         M_AXI_AWPROT,
    output logic               M_AXI_AWVALID,
    input  logic               M_AXI_AWREADY,
    output logic [DATAW-1:0]   M_AXI_WDATA,
    output logic [DATAW/8-1:0] M_AXI_WSTRB,
    output logic               M_AXI_WVALID,
    input  logic               M_AXI_WREADY,
    input  logic [1:0]         M_AXI_BRESP,
    input  logic               M_AXI_BVALID,
    output logic               M_AXI_BREADY,
    output logic [ADDRW-1:0]   M_AXI_ARADDR,
    output logic [2:0]         M_AXI_ARPROT,
    output logic               M_AXI_ARVALID,
    input  logic               M_AXI_ARREADY,
    input  logic [DATAW-1:0]   M_AXI_RDATA,
    input  logic [1:0]         M_AXI_RRESP,
    input  logic               M_AXI_RVALID,
    output logic               M_AXI_RREADY
);

    mst_state_t state, state_nxt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done, w_done;
    logic cmd_accept;
    logic rsp_load;
    logic expire;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs       = M_AXI_BVALID & M_AXI_BREADY;
    assign ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs       = M_AXI_RVALID & M_AXI_RREADY;
    assign cmd_accept = (state == IDLE) & cmd_valid_i & cmd_ready_o;
    assign rsp_load   = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge clk100) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_accept) state_nxt = cmd_we_i ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = DONE;
            RD_REQ:  if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (expire) state_nxt = DONE;
    end

    // Every output is a flop loaded from the next state, so nothing reaches a port
    // combinationally from a READY input.
    always_ff @(posedge clk100) begin
        if (rst) begin
            cmd_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_resp_o    <= OKAY;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_ARADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
        end else begin
            cmd_ready_o   <= (state_nxt == IDLE);
            rsp_valid_o   <= (state_nxt == DONE);
            aw_done       <= (state_nxt == WR_REQ) && (aw_done || aw_hs);
            w_done        <= (state_nxt == WR_REQ) && (w_done || w_hs);
            M_AXI_AWVALID <= (state_nxt == WR_REQ) && !(aw_done || aw_hs);
            M_AXI_WVALID  <= (state_nxt == WR_REQ) && !(w_done || w_hs);
            M_AXI_BREADY  <= (state_nxt == WR_RESP);
            M_AXI_ARVALID <= (state_nxt == RD_REQ);
            M_AXI_RREADY  <= (state_nxt == RD_DATA);

            if (cmd_accept) begin
                if (cmd_we_i) begin
                    M_AXI_AWADDR <= cmd_addr_i;
                    M_AXI_WDATA  <= cmd_wdata_i;
                    M_AXI_WSTRB  <= cmd_wstrb_i;
                end else begin
                    M_AXI_ARADDR <= cmd_addr_i;
                end
            end

            if (rsp_load) begin
                if (expire) begin
                    rsp_resp_o  <= SLVERR;
                    rsp_rdata_o <= '0;
                end else if (state == WR_RESP) begin
                    rsp_resp_o  <= M_AXI_BRESP;
                    rsp_rdata_o <= '0;
                end else begin
                    rsp_resp_o  <= M_AXI_RRESP;
                    rsp_rdata_o <= M_AXI_RDATA;
                end
            end
        end
    end

`ifdef AXIL_MST_TIMEOUT_EN
    logic wdog_clr, wdog_en;

    assign wdog_clr = (state == IDLE);
    assign wdog_en  = (state != IDLE) && (state != DONE);

    axil_mst_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk100),
        .rst    (rst),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (expire)
    );

    always_ff @(posedge clk100) begin
        if (rst) begin
            rsp_timeout_o <= 1'b0;
        end else if (rsp_load) begin
            rsp_timeout_o <= expire;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign expire         = 1'b0;
    assign rsp_timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_axil_mst_cmd.sv
// Directed bench for axil_mst_cmd against a small AXI-Lite register responder with per-channel delays.
module tb_axil_mst_cmd;

    logic        clk100 = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_we;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        cmd_ready_o, rsp_valid_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic [6:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk100 = ~clk100;

    axil_mst_cmd #(.ADDRW(7), .DATAW(32), .TIMEOUT(16)) dut (
        .clk100(clk100), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .rsp_timeout_o(rsp_timeout_o),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int n_chk, n_fail;
    int aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic [1:0] rresp_cfg;

    // Handshake monitor: counters and one-cycle handshake flags for the responder.
    int n_awv, n_wv, n_bhs, n_rsp, n_acc, n_viol;
    logic hs_aw_q, hs_w_q, hs_b_q, hs_ar_q, hs_r_q;
    logic [31:0] last_rdata;

    always @(posedge clk100) begin
        hs_aw_q <= M_AXI_AWVALID && M_AXI_AWREADY;
        hs_w_q  <= M_AXI_WVALID && M_AXI_WREADY;
        hs_b_q  <= M_AXI_BVALID && M_AXI_BREADY;
        hs_ar_q <= M_AXI_ARVALID && M_AXI_ARREADY;
        hs_r_q  <= M_AXI_RVALID && M_AXI_RREADY;
        if (M_AXI_AWVALID) n_awv <= n_awv + 1;
        if (M_AXI_WVALID) n_wv <= n_wv + 1;
        if (M_AXI_BVALID && M_AXI_BREADY) n_bhs <= n_bhs + 1;
        if (rsp_valid_o) begin
            n_rsp      <= n_rsp + 1;
            last_rdata <= rsp_rdata_o;
        end
        if (cmd_valid && cmd_ready_o) n_acc <= n_acc + 1;
        if (cmd_ready_o && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY ||
                            M_AXI_ARVALID || M_AXI_RREADY || rsp_valid_o))
            n_viol <= n_viol + 1;
    end

    // Register-file responder, updated mid-cycle so its outputs are stable at each rising edge.
    logic [31:0] mem [32];
    int aw_cnt, w_cnt, b_cnt, r_cnt;
    logic got_aw, got_w, b_pend, r_pend;
    logic [31:0] r_lat;

    always @(negedge clk100) begin
        if (rst) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
            M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
            got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0; r_lat = '0;
            for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
        end else begin
            if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
            if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; end
            else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
            if (hs_aw_q) got_aw = 1'b1;
            if (hs_w_q) got_w = 1'b1;
            if (hs_b_q) begin b_pend = 1'b0; M_AXI_BVALID = 1'b0; end
            if (got_aw && got_w && !b_pend) begin
                for (int b = 0; b < 4; b++)
                    if (M_AXI_WSTRB[b]) mem[M_AXI_AWADDR[6:2]][8*b +: 8] = M_AXI_WDATA[8*b +: 8];
                got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1; b_cnt = 0;
            end
            if (b_pend) begin
                if (b_cnt >= b_delay) M_AXI_BVALID = 1'b1;
                b_cnt++;
            end
            if (M_AXI_ARVALID) M_AXI_ARREADY = 1'b1;
            else M_AXI_ARREADY = 1'b0;
            if (hs_r_q) begin r_pend = 1'b0; M_AXI_RVALID = 1'b0; end
            if (hs_ar_q) begin r_pend = 1'b1; r_cnt = 0; r_lat = mem[M_AXI_ARADDR[6:2]]; end
            if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    M_AXI_RVALID = 1'b1; M_AXI_RDATA = r_lat; M_AXI_RRESP = rresp_cfg;
                end
                r_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int g = 0;
        while (!cmd_ready_o && g < 50) begin tick(); g++; end
        if (g >= 50) chk({tag, "_rdy_wait"}, 32'(cmd_ready_o), 32'd1);
    endtask

    // Issues one command and returns the cycle count from the accepting edge to rsp_valid_o.
    task automatic do_cmd(input string tag, input logic we, input logic [6:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, output int lat);
        cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        wait_ready(tag);
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 100) begin tick(); lat++; end
    endtask

    task automatic chk_rsp(input string tag, input int lat, input int exp_lat,
                           input logic [1:0] exp_resp, input logic [31:0] exp_rdata, input logic exp_to);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_resp"}, 32'(rsp_resp_o), 32'(exp_resp));
        chk({tag, "_rdata"}, rsp_rdata_o, exp_rdata);
        chk({tag, "_tmo"}, 32'(rsp_timeout_o), 32'(exp_to));
        tick();
        chk({tag, "_pulse"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_rdy"}, 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        int lat, s_awv, s_wv, s_bhs, s_rsp, s_acc, s_viol, g;
        n_chk = 0; n_fail = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0; rresp_cfg = 2'b00;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid_o, rsp_timeout_o, rsp_resp_o}), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_addr", 32'({M_AXI_AWADDR, M_AXI_ARADDR}), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_ready", 32'(cmd_ready_o), 32'd1);

        s_awv = n_awv; s_wv = n_wv; s_bhs = n_bhs;
        do_cmd("wr08", 1'b1, 7'h08, 32'h0000_0005, 4'hF, lat);
        chk("wr08_prot", 32'({M_AXI_AWPROT, M_AXI_ARPROT}), 32'd0);
        chk_rsp("wr08", lat, 3, 2'b00, 32'd0, 1'b0);
        chk("wr08_awv", 32'(n_awv - s_awv), 32'd1);
        chk("wr08_bhs", 32'(n_bhs - s_bhs), 32'd1);

        do_cmd("rd08", 1'b0, 7'h08, 32'd0, 4'h0, lat);
        chk_rsp("rd08", lat, 3, 2'b00, 32'h0000_0005, 1'b0);

        aw_delay = 3;
        s_awv = n_awv; s_wv = n_wv; s_bhs = n_bhs;
        do_cmd("wr_awslow", 1'b1, 7'h0C, 32'h1234_5678, 4'hF, lat);
        chk_rsp("wr_awslow", lat, 6, 2'b00, 32'd0, 1'b0);
        chk("wr_awslow_awv", 32'(n_awv - s_awv), 32'd4);
        chk("wr_awslow_wv", 32'(n_wv - s_wv), 32'd1);
        chk("wr_awslow_bhs", 32'(n_bhs - s_bhs), 32'd1);
        aw_delay = 0; w_delay = 2;
        s_awv = n_awv; s_wv = n_wv;
        do_cmd("wr_wslow", 1'b1, 7'h0C, 32'hCAFE_F00D, 4'hF, lat);
        chk_rsp("wr_wslow", lat, 5, 2'b00, 32'd0, 1'b0);
        chk("wr_wslow_awv", 32'(n_awv - s_awv), 32'd1);
        chk("wr_wslow_wv", 32'(n_wv - s_wv), 32'd3);
        w_delay = 0;
        do_cmd("rd0c", 1'b0, 7'h0C, 32'd0, 4'h0, lat);
        chk_rsp("rd0c", lat, 3, 2'b00, 32'hCAFE_F00D, 1'b0);

        r_delay = 5; rresp_cfg = 2'b11;
        s_rsp = n_rsp;
        do_cmd("rd00_slow", 1'b0, 7'h00, 32'd0, 4'h0, lat);
        chk_rsp("rd00_slow", lat, 8, 2'b11, 32'hA5A5_0000, 1'b0);
        chk("rd00_slow_npulse", 32'(n_rsp - s_rsp), 32'd1);
        r_delay = 0; rresp_cfg = 2'b00;

        do_cmd("wr10_part", 1'b1, 7'h10, 32'hDEAD_BEEF, 4'h3, lat);
        chk_rsp("wr10_part", lat, 3, 2'b00, 32'd0, 1'b0);
        do_cmd("rd10", 1'b0, 7'h10, 32'd0, 4'h0, lat);
        chk_rsp("rd10", lat, 3, 2'b00, 32'hA5A5_BEEF, 1'b0);

        // Three back-to-back commands with cmd_valid never dropping in between.
        s_rsp = n_rsp; s_acc = n_acc; s_viol = n_viol;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_we    = (k < 2);
            cmd_addr  = (k == 1) ? 7'h18 : 7'h14;
            cmd_wdata = (k == 1) ? 32'h22 : 32'h11;
            cmd_wstrb = 4'hF;
            wait_ready("queue");
            tick();
        end
        cmd_valid = 1'b0;
        g = 0;
        while ((n_rsp - s_rsp) < 3 && g < 50) begin tick(); g++; end
        repeat (6) tick();
        chk("queue_nrsp", 32'(n_rsp - s_rsp), 32'd3);
        chk("queue_nacc", 32'(n_acc - s_acc), 32'd3);
        chk("queue_ready_viol", 32'(n_viol - s_viol), 32'd0);
        chk("queue_rdata", last_rdata, 32'h0000_0011);

        // Reset while the write waits in the response phase.
        b_delay = 6;
        cmd_we = 1'b1; cmd_addr = 7'h1C; cmd_wdata = 32'h77; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        wait_ready("rst_mid");
        tick();
        cmd_valid = 1'b0;
        g = 0;
        while (!M_AXI_BREADY && g < 20) begin tick(); g++; end
        chk("rst_mid_bready", 32'(M_AXI_BREADY), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_mid_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        chk("rst_mid_rsp", 32'({rsp_valid_o, rsp_timeout_o, rsp_resp_o}), 32'd0);
        chk("rst_mid_rdata", rsp_rdata_o, 32'd0);
        chk("rst_mid_wdata", M_AXI_WDATA, 32'd0);
        chk("rst_mid_addr", 32'({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB}), 32'd0);
        rst = 1'b0; b_delay = 0;
        tick();
        chk("rst_mid_rel_ready", 32'(cmd_ready_o), 32'd1);
        do_cmd("rd_after_rst", 1'b0, 7'h08, 32'd0, 4'h0, lat);
        chk_rsp("rd_after_rst", lat, 3, 2'b00, 32'hA5A5_0002, 1'b0);

`ifdef AXIL_MST_TIMEOUT_EN
        aw_delay = 1000; w_delay = 1000;
        do_cmd("tmo", 1'b1, 7'h04, 32'h55, 4'hF, lat);
        chk_rsp("tmo", lat, 17, 2'b10, 32'd0, 1'b1);
        chk("tmo_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 32'd0);
        aw_delay = 0; w_delay = 0;
        tick();
        do_cmd("rd_after_tmo", 1'b0, 7'h0C, 32'd0, 4'h0, lat);
        chk_rsp("rd_after_tmo", lat, 3, 2'b00, 32'hA5A5_0003, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
